// File: rtl/axburst_split.sv
// axburst_split: turns one byte-granular DMA descriptor into a run of AXI INCR
// bursts on an AW/AR address channel.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cfg_valid/cfg_ready      descriptor handshake (ready only while idle)
//   cfg_sa, cfg_len, cfg_id  start byte address, byte length, burst ID
//   axid/axaddr/axlen/axsize/axburst/axvalid/axready
//                            AXI address channel (INCR only)
//   ax_strb_first            byte mask for beat 0 of the current burst
//   ax_strb_last             byte mask for the final beat of the current burst
//   done                     one-cycle pulse after the last burst is accepted
//
// ALIGN=1 ends every burst on a MAX_BL-beat boundary; ALIGN=0 issues bursts of
// up to MAX_BL beats and only splits where a BOUND boundary would be crossed.
module axburst_split #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int MAX_BL     = 16,
  parameter int BOUND      = 4096,
  parameter int ALIGN      = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [AXI_AW-1:0]       cfg_sa,
  input  logic [31:0]             cfg_len,
  input  logic [AXI_IW-1:0]       cfg_id,
  output logic [AXI_IW-1:0]       axid,
  output logic [AXI_AW-1:0]       axaddr,
  output logic [AXI_LW-1:0]       axlen,
  output logic [AXI_SW-1:0]       axsize,
  output logic [AXI_BURSTW-1:0]   axburst,
  output logic                    axvalid,
  input  logic                    axready,
  output logic [AXI_DW/8-1:0]     ax_strb_first,
  output logic [AXI_DW/8-1:0]     ax_strb_last,
  output logic                    done
);

  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int WAW       = AXI_AW - L;
  localparam int BPB       = BOUND / AXI_BYTES;   // beats per BOUND window
  localparam logic [AXI_BYTES-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

  state_t          state, state_next;
  logic [WAW-1:0]  wa;
  logic [L-1:0]    off;
  logic [L-1:0]    eoff;
  logic [31:0]     rem;
  logic [AXI_IW-1:0] id;
  logic            first;

  logic [31:0]     wa32;
  logic [31:0]     lim;
  logic [31:0]     n;
  logic            last_burst;
  logic            cfg_acc;
  logic            ax_acc;
  logic [33:0]     rem_init;
  logic [L-1:0]    eoff_init;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Burst sizing: everything below depends only on registered state, so the
  // ax* outputs cannot glitch with axready.
  always_comb begin
    wa32 = 32'(wa);
    if (ALIGN != 0)
      lim = 32'(MAX_BL) - (wa32 & 32'(MAX_BL - 1));
    else
      lim = min32(32'(MAX_BL), 32'(BPB) - (wa32 & 32'(BPB - 1)));
    n          = min32(rem, lim);
    last_burst = (n == rem);
  end

  assign cfg_acc   = cfg_valid && (state == IDLE);
  assign ax_acc    = axready && (state == BUSY);
  // 34 bits so off + len + (AXI_BYTES-1) cannot overflow before the shift.
  assign rem_init  = 34'(cfg_sa[L-1:0]) + 34'(cfg_len) + 34'(AXI_BYTES - 1);
  // Only the low L bits of the end address matter, so add them modulo 2^L.
  assign eoff_init = cfg_sa[L-1:0] + cfg_len[L-1:0] - L'(1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cfg_valid) state_next = (cfg_len == 32'd0) ? FIN : BUSY;
      BUSY: if (axready && last_burst) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Descriptor / progress registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wa    <= '0;
      off   <= '0;
      eoff  <= '0;
      rem   <= '0;
      id    <= '0;
      first <= 1'b0;
    end else if (cfg_acc) begin
      wa    <= cfg_sa[AXI_AW-1:L];
      off   <= cfg_sa[L-1:0];
      eoff  <= eoff_init;
      rem   <= 32'(rem_init >> L);
      id    <= cfg_id;
      first <= 1'b1;
    end else if (ax_acc) begin
      wa    <= wa + WAW'(n);     // wraps with the address space
      rem   <= rem - n;
      first <= 1'b0;
    end
  end

  // Address channel outputs
  assign cfg_ready     = (state == IDLE);
  assign axvalid       = (state == BUSY);
  assign done          = (state == FIN);
  assign axid          = id;
  assign axaddr        = {wa, (first ? off : L'(0))};
  assign axlen         = AXI_LW'(n - 32'd1);
  assign axsize        = AXI_SW'(L);
  assign axburst       = AXI_BURSTW'(1);
  assign ax_strb_first = first ? (ONES << off) : ONES;
  // Keep bytes 0..eoff of the final beat.
  assign ax_strb_last  = last_burst ? (ONES >> (L'(AXI_BYTES - 1) - eoff)) : ONES;

endmodule

// File: tb/tb_axburst_split.sv
module tb_axburst_split;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [15:0] sf;
    logic [15:0] sl;
  } burst_t;

  logic clk;
  logic reset_n;

  logic        cfg_valid [2];
  logic        cfg_ready [2];
  logic [31:0] cfg_sa    [2];
  logic [31:0] cfg_len   [2];
  logic [7:0]  cfg_id    [2];
  logic [7:0]  axid      [2];
  logic [31:0] axaddr    [2];
  logic [7:0]  axlen     [2];
  logic [2:0]  axsize    [2];
  logic [1:0]  axburst   [2];
  logic        axvalid   [2];
  logic        axready   [2];
  logic [15:0] strb_f    [2];
  logic [15:0] strb_l    [2];
  logic        done      [2];

  int errors = 0;
  int checks = 0;
  burst_t exp_q[$];

  // Instance 0 uses MAX_BL-aligned splitting, instance 1 splits only at BOUND.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    axburst_split #(
      .AXI_DW(128), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .AXI_SW(3),
      .AXI_BURSTW(2), .MAX_BL(16), .BOUND(4096), .ALIGN((g == 0) ? 1 : 0)
    ) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_valid(cfg_valid[g]), .cfg_ready(cfg_ready[g]),
      .cfg_sa(cfg_sa[g]), .cfg_len(cfg_len[g]), .cfg_id(cfg_id[g]),
      .axid(axid[g]), .axaddr(axaddr[g]), .axlen(axlen[g]),
      .axsize(axsize[g]), .axburst(axburst[g]),
      .axvalid(axvalid[g]), .axready(axready[g]),
      .ax_strb_first(strb_f[g]), .ax_strb_last(strb_l[g]),
      .done(done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the byte range in 16-byte words, cutting a burst at
  // the first of: end of data, 16 beats, or the split boundary for the mode.
  task automatic build(input int align, input logic [31:0] sa, input logic [31:0] len);
    longint unsigned a, endb, w, lastw, bnd, nb, lb, m;
    burst_t e;
    bit first;
    exp_q.delete();
    a = sa; endb = longint'(sa) + longint'(len); first = 1;
    while (a < endb) begin
      w = a / 16;
      lastw = (endb - 1) / 16;
      if (align != 0) bnd = (w / 16 + 1) * 16;
      else begin
        bnd = (w / 256 + 1) * 256;
        if (w + 16 < bnd) bnd = w + 16;
      end
      nb = lastw - w + 1;
      if (bnd - w < nb) nb = bnd - w;
      e.addr = 32'(a);
      e.len  = 8'(nb - 1);
      m = 64'hFFFF << (sa % 16);
      e.sf = first ? 16'(m) : 16'hFFFF;
      lb = (endb - 1) % 16;
      m = (64'h1 << (lb + 1)) - 1;
      e.sl = (w + nb - 1 == lastw) ? 16'(m) : 16'hFFFF;
      exp_q.push_back(e);
      a = (w + nb) * 16;
      first = 0;
    end
  endtask

  // Starts and ends just after a rising edge. bp: 0 none, 1 random stalls,
  // 2 random stalls plus a 5-cycle stall on the second burst.
  task automatic run_desc(input int i, input logic [31:0] sa, input logic [31:0] len,
                          input logic [7:0] id, input int bp);
    int stall;
    int t;
    build((i == 0) ? 1 : 0, sa, len);
    t = 0;
    while (!cfg_ready[i] && t < 20) begin
      @(posedge clk); #1; t++;
    end
    cfg_sa[i] = sa; cfg_len[i] = len; cfg_id[i] = id; cfg_valid[i] = 1'b1;
    @(negedge clk);
    chk("cfg_ready_idle", cfg_ready[i], 1);
    @(posedge clk); #1;
    cfg_valid[i] = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      stall = (bp != 0) ? int'($urandom_range(0, 2)) : 0;
      if (bp == 2 && j == 1) stall = 5;
      for (int s = 0; s <= stall; s++) begin
        axready[i] = (s == stall);
        if (s == 0 && stall > 0) begin
          cfg_valid[i] = 1'b1;          // must be ignored while busy
          cfg_sa[i] = $urandom;
          cfg_len[i] = 32'd64;
        end else cfg_valid[i] = 1'b0;
        @(negedge clk);
        chk("axvalid", axvalid[i], 1);
        chk("axaddr", axaddr[i], exp_q[j].addr);
        chk("axlen", axlen[i], exp_q[j].len);
        chk("strb_first", strb_f[i], exp_q[j].sf);
        chk("strb_last", strb_l[i], exp_q[j].sl);
        chk("axid", axid[i], id);
        chk("axsize", axsize[i], 3'd4);
        chk("axburst", axburst[i], 2'b01);
        chk("cfg_ready_busy", cfg_ready[i], 0);
        chk("done_busy", done[i], 0);
        @(posedge clk); #1;
      end
      axready[i] = 1'b0;
      cfg_valid[i] = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", done[i], 1);
    chk("axvalid_fin", axvalid[i], 0);
    chk("cfg_ready_fin", cfg_ready[i], 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_cleared", done[i], 0);
    chk("cfg_ready_back", cfg_ready[i], 1);
    chk("axvalid_idle", axvalid[i], 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] sa;
    logic [31:0] len;
    int inst;
    for (int i = 0; i < 2; i++) begin
      cfg_valid[i] = 0; cfg_sa[i] = 0; cfg_len[i] = 0; cfg_id[i] = 0; axready[i] = 0;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cfg_ready", cfg_ready[i], 1);
      chk("rst_axvalid", axvalid[i], 0);
      chk("rst_done", done[i], 0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_desc(0, 32'h0000_1000, 32'h400, 8'h11, 0);   // aligned, 4 full bursts
    run_desc(0, 32'h0000_1030, 32'h100, 8'h22, 0);   // misaligned word
    run_desc(1, 32'h0000_0FC0, 32'h200, 8'h33, 0);   // BOUND split mode
    run_desc(0, 32'h0000_2005, 32'h20,  8'h44, 0);   // unaligned bytes
    run_desc(1, 32'h0000_2005, 32'h20,  8'h45, 0);
    run_desc(0, 32'h0000_3000, 32'h400, 8'h55, 2);   // backpressure
    run_desc(1, 32'h0000_0F00, 32'h300, 8'h56, 2);
    run_desc(0, 32'h0000_4000, 32'h0,   8'h66, 0);   // zero length
    run_desc(0, 32'hFFFF_FFF3, 32'h40,  8'h77, 0);   // address wrap
    run_desc(1, 32'hFFFF_FF83, 32'h100, 8'h78, 1);

    // Reset during the second of four bursts.
    build(1, 32'h0000_1000, 32'h400);
    cfg_sa[0] = 32'h0000_1000; cfg_len[0] = 32'h400; cfg_id[0] = 8'h99; cfg_valid[0] = 1;
    @(posedge clk); #1;
    cfg_valid[0] = 0; axready[0] = 1;
    @(negedge clk);
    chk("rstmid_b0_addr", axaddr[0], 32'h0000_1000);
    @(posedge clk); #1;
    axready[0] = 0;
    @(negedge clk);
    chk("rstmid_b1_addr", axaddr[0], 32'h0000_1100);
    chk("rstmid_b1_valid", axvalid[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_axvalid", axvalid[0], 0);
    chk("rstmid_cfg_ready", cfg_ready[0], 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstrel_cfg_ready", cfg_ready[0], 1);
      chk("rstrel_axvalid", axvalid[0], 0);
      chk("rstrel_done", done[0], 0);
    end
    @(posedge clk); #1;
    run_desc(0, 32'h0000_1000, 32'h400, 8'h9A, 0);

    // Randomized descriptors on both instances.
    for (int k = 0; k < 40; k++) begin
      inst = int'($urandom_range(0, 1));
      sa = $urandom;
      if (k % 8 == 3) sa = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFF);
      len = (k % 10 == 7) ? 32'd0 : $urandom_range(1, 1500);
      run_desc(inst, sa, len, 8'($urandom), int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axburst_split.md
Name: axburst_split

Overview:
- Next-generation AXI AW/AR burst generator for the DMA engines.
- Accepts one byte-granular DMA descriptor (start address, byte length, ID) and emits a sequence of INCR bursts on an AXI address channel.
- Supports unaligned start and end bytes, a configurable maximum burst length, and two split modes: MAX_BL-aligned, or split only at the BOUND (4KB) boundary.
- Emits per-burst first/last-beat byte strobes for the companion W-channel packer, and a done pulse.

Parameters:
- AXI_DW, 128: data bus width in bits; AXI_BYTES = AXI_DW/8, L = log2(AXI_BYTES).
- AXI_AW, 32: address width (<= 32).
- AXI_IW, 8: ID width.
- AXI_LW, 8: AxLEN width.
- AXI_SW, 3: AxSIZE width.
- AXI_BURSTW, 2: AxBURST width.
- MAX_BL, 16: maximum beats per burst; power of 2, 1..2^AXI_LW.
- BOUND, 4096: no-cross boundary in bytes; power of 2, >= MAX_BL*AXI_BYTES.
- ALIGN, 1: 1 = bursts end on MAX_BL-beat boundaries; 0 = bursts are up to MAX_BL beats and split only at BOUND.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: asynchronous active-low reset.
- cfg_valid, in, 1: descriptor valid.
- cfg_ready, out, 1: descriptor ready; high only in IDLE.
- cfg_sa, in, AXI_AW: start byte address.
- cfg_len, in, 32: length in bytes.
- cfg_id, in, AXI_IW: ID driven on every burst of the descriptor.
- axid, out, AXI_IW: burst ID.
- axaddr, out, AXI_AW: burst address.
- axlen, out, AXI_LW: beats-1.
- axsize, out, AXI_SW: constant log2(AXI_BYTES).
- axburst, out, AXI_BURSTW: constant 2'b01 (INCR).
- axvalid, out, 1: burst valid.
- axready, in, 1: burst accept.
- ax_strb_first, out, AXI_BYTES: byte mask for beat 0 of the current burst.
- ax_strb_last, out, AXI_BYTES: byte mask for the final beat of the current burst.
- done, out, 1: one-cycle pulse when the descriptor completes.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: state IDLE, axvalid=0, done=0, cfg_ready=1, internal address/count/id registers 0. Asserting reset mid-descriptor drops axvalid immediately and discards the descriptor.
- States: IDLE, BUSY, FIN.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready, latch word address wa = cfg_sa[AXI_AW-1:L], byte offset off = cfg_sa[L-1:0], id, and end offset eoff = (cfg_sa+cfg_len-1)[L-1:0].
  - Also latch rem = (off + cfg_len + AXI_BYTES-1) >> L, using a 34-bit intermediate; no overflow allowed.
  - cfg_len=0 -> FIN; otherwise -> BUSY.
- BUSY: axvalid=1.
  - Burst beats n = min(rem, lim).
  - ALIGN=1: lim = MAX_BL - (wa mod MAX_BL).
  - ALIGN=0: lim = min(MAX_BL, BOUND/AXI_BYTES - (wa mod (BOUND/AXI_BYTES))).
  - axlen = n-1.
  - axaddr: first burst = {wa,off} (unaligned byte address); later bursts = {wa,L'(0)}.
- Strobes: ax_strb_first = first burst ? (all-ones << off) : all-ones. ax_strb_last = last burst (n==rem) ? (all-ones >> (AXI_BYTES-1-eoff)) : all-ones.
  - For a single-beat transfer the W packer ANDs the two masks; this block does not merge them.
- All ax* outputs are pure functions of registered state and hold stable while axvalid & !axready. No combinational path from axready to any ax* output.
- On axvalid&axready: wa += n (wraps modulo 2^(AXI_AW-L)), rem -= n, first flag cleared. If n==rem -> FIN in the same edge.
- Back-to-back bursts: one burst per cycle while axready=1.
- FIN: done=1 for exactly one cycle, then IDLE. cfg_ready=0 in BUSY and FIN, so there is no descriptor overlap.
- Latency: cfg handshake at edge k -> axvalid high in cycle k+1. Final burst handshake at edge m -> done in cycle m+1 -> cfg_ready in cycle m+2.
- cfg_* inputs are ignored outside IDLE.
- Address wrap past 2^AXI_AW is not flagged. Bursts still never cross BOUND, because 2^AXI_AW is a BOUND multiple.

Test Plan:
- Aligned, ALIGN=1, sa=0x1000, len=0x400 -> 4 bursts at 0x1000/0x1100/0x1200/0x1300, axlen=15 each, strobes 0xFFFF, done once.
- Misaligned word, ALIGN=1, sa=0x1030, len=0x100 -> axaddr 0x1030 axlen=12, then 0x1100 axlen=2.
- Boundary, ALIGN=0, sa=0x0FC0, len=0x200 -> 0x0FC0 axlen=3, 0x1000 axlen=15, 0x1100 axlen=11; no burst crosses 0x1000.
- Unaligned bytes, sa=0x2005, len=0x20 -> single burst axaddr=0x2005, axlen=2, ax_strb_first=0xFFE0, ax_strb_last=0x001F.
- Backpressure: axready low 5 cycles mid-sequence -> axaddr/axlen/strobes stable, cfg_ready=0; a cfg_valid pulse during BUSY is ignored and no extra bursts are issued.
- len=0 -> no axvalid, done pulse 1 cycle after acceptance. Assert reset_n low during the 2nd of 4 bursts -> axvalid=0 immediately, IDLE and cfg_ready=1 after release.
